// File: rtl/dst7_1d_seq.sv
// dst7_1d_seq - sequential 4/8-point DST-VII 1D stage.
//   One input vector is captured per transaction. A single shared row-MAC
//   produces one output row per cycle; each row gets an optional round-half-up
//   shift and is then saturated to OUT_W bits.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; X, size8, inverse captured on accept
//   X                    8 x IN_W signed samples, element i at [i*IN_W +: IN_W]
//   out_valid/out_ready  output handshake; Y is valid only while out_valid = 1
//   Y                    8 x OUT_W signed results, element k at [k*OUT_W +: OUT_W]
module dst7_1d_seq #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 size8,
  input  logic                 inverse,
  input  logic [8*IN_W-1:0]    X,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   Y
);

  localparam int ACC_W = IN_W + 9;
  // Wide enough for the rounding add and for holding the OUT_W bounds.
  localparam int RW = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W + 1;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Forward matrices, row-major: index = {row, col}.
  localparam int C8 [64] = '{
     11,  22,  33,  42,  50,  56,  60,  62,
     33,  56,  62,  50,  22, -11, -42, -60,
     50,  60,  22, -33, -62, -42,  11,  56,
     60,  33, -42, -56,  11,  62,  22, -50,
     62, -11, -60,  22,  56, -33, -50,  42,
     56, -50, -11,  60, -42, -22,  62, -33,
     42, -62,  50, -11, -33,  60, -56,  22,
     22, -42,  56, -62,  60, -50,  33, -11};
  localparam int C4 [16] = '{
     29,  55,  74,  84,
     74,  74,   0, -74,
     84, -29, -74,  55,
     55, -84,  74, -29};

  function automatic int coef(input logic s8, input logic [2:0] r, input logic [2:0] c);
    if (s8) return C8[{r, c}];
    else    return C4[{r[1:0], c[1:0]}];
  endfunction

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           row_q;
  logic                 size8_q, inv_q;
  logic [8*IN_W-1:0]    x_q;
  logic [8*OUT_W-1:0]   y_q;
  logic                 accept, last_row;

  logic signed [ACC_W-1:0] acc;
  logic signed [RW-1:0]    rnd, sat;

  // Row MAC over the captured vector; inverse mode walks a matrix column.
  always_comb begin
    int cf;
    acc = '0;
    cf  = 0;
    for (int n = 0; n < 8; n++) begin
      cf = inv_q ? coef(size8_q, 3'(n), row_q) : coef(size8_q, row_q, 3'(n));
      if (size8_q || n < 4)
        acc = acc + ACC_W'($signed(x_q[n*IN_W +: IN_W])) * ACC_W'(cf);
    end
  end

  generate
    if (SHIFT > 0) begin : g_round
      assign rnd = (RW'(acc) + (RW'(1) <<< (SHIFT - 1))) >>> SHIFT;
    end else begin : g_noround
      assign rnd = RW'(acc);
    end
  endgenerate

  always_comb begin
    sat = rnd;
    if (rnd > MAXV)      sat = MAXV;
    else if (rnd < MINV) sat = MINV;
  end

  assign last_row = (row_q == (size8_q ? 3'd7 : 3'd3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: if (last_row) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        // Releasing the result frees the block in the same cycle.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      size8_q <= 1'b0;
      inv_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (accept) begin
      x_q     <= X;
      size8_q <= size8;
      inv_q   <= inverse;
      row_q   <= '0;
      // Upper half is never written by a 4-point run.
      if (!size8) y_q[8*OUT_W-1:4*OUT_W] <= '0;
    end else if (state_q == CALC) begin
      y_q[row_q*OUT_W +: OUT_W] <= sat[OUT_W-1:0];
      row_q <= row_q + 3'd1;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_dst7_1d_seq.sv
module tb_dst7_1d_seq;
  localparam int IN_W  = 9;
  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, size8 = 1'b0, inverse = 1'b0, out_ready = 1'b0;
  logic [8*IN_W-1:0]  X = '0;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [8*OUT_W-1:0] Y, Y2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dst7_1d_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .size8(size8), .inverse(inverse), .X(X),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y));

  dst7_1d_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .size8(size8), .inverse(inverse), .X(X),
    .out_valid(out_valid2), .out_ready(out_ready), .Y(Y2));

  int C8 [8][8] = '{
    '{11, 22, 33, 42, 50, 56, 60, 62},
    '{33, 56, 62, 50, 22, -11, -42, -60},
    '{50, 60, 22, -33, -62, -42, 11, 56},
    '{60, 33, -42, -56, 11, 62, 22, -50},
    '{62, -11, -60, 22, 56, -33, -50, 42},
    '{56, -50, -11, 60, -42, -22, 62, -33},
    '{42, -62, 50, -11, -33, 60, -56, 22},
    '{22, -42, 56, -62, 60, -50, 33, -11}};
  int C4 [4][4] = '{
    '{29, 55, 74, 84},
    '{74, 74, 0, -74},
    '{84, -29, -74, 55},
    '{55, -84, 74, -29}};

  // Reference: matrix-vector product, rounding shift, saturation.
  function automatic logic [8*OUT_W-1:0] model(input int x[8], input bit s8, input bit inv, input int sh);
    logic [8*OUT_W-1:0] res;
    int n, acc, r, c;
    res = '0;
    n = s8 ? 8 : 4;
    for (int k = 0; k < n; k++) begin
      acc = 0;
      for (int j = 0; j < n; j++) begin
        if (s8) c = inv ? C8[j][k] : C8[k][j];
        else    c = inv ? C4[j][k] : C4[k][j];
        acc += c * x[j];
      end
      r = (sh > 0) ? ((acc + (1 << (sh - 1))) >>> sh) : acc;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      res[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
    end
    return res;
  endfunction

  function automatic logic [8*OUT_W-1:0] pack_y(input int y[8]);
    logic [8*OUT_W-1:0] res;
    for (int k = 0; k < 8; k++) res[k*OUT_W +: OUT_W] = y[k][OUT_W-1:0];
    return res;
  endfunction

  // Presents a vector until accepted, then scrambles the inputs so that any
  // dependence on post-accept input values shows up in the result.
  task automatic send(input int x[8], input bit s8, input bit inv, output bit ok);
    for (int i = 0; i < 8; i++) X[i*IN_W +: IN_W] = x[i][IN_W-1:0];
    size8 = s8; inverse = inv; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) X[i*IN_W +: IN_W] = IN_W'($urandom);
    size8 = ~s8; inverse = ~inv;
  endtask

  // Edges counted from the accept edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Y !== '0 || Y2 !== '0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b Y=%h Y2=%h, required 1 0 0 0", in_ready, out_valid, Y, Y2);
    end
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Directed transaction against constants; latency in edges after the accept
  // edge (out_valid in cycle t+N+1 means N edges after the accept edge).
  task automatic run_directed(input string name, input int x[8], input bit s8, input bit inv,
                              input int yexp[8], input int lat);
    bit ok;
    int n;
    logic [8*OUT_W-1:0] e;
    e = pack_y(yexp);
    send(x, s8, inv, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_accept: in_ready never seen", name); end
    wait_valid(n);
    tests++;
    if (n !== lat) begin fails++; $display("FAIL %s_latency: got %0d edges, required %0d", name, n, lat); end
    tests++;
    if (Y !== e) begin fails++; $display("FAIL %s_Y: got %h required %h", name, Y, e); end
    release_out();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_fwd8_impulse();
    run_directed("fwd8_impulse", '{1,0,0,0,0,0,0,0}, 1'b1, 1'b0, '{11,33,50,60,62,56,42,22}, 8);
  endtask

  task automatic test_inv8_impulse();
    run_directed("inv8_impulse", '{1,0,0,0,0,0,0,0}, 1'b1, 1'b1, '{11,22,33,42,50,56,60,62}, 8);
  endtask

  task automatic test_fwd4();
    // Upper samples are junk and must be ignored; Y[7:4] must be zero.
    run_directed("fwd4", '{0,1,0,0,100,-77,5,255}, 1'b0, 1'b0, '{55,74,-29,-84,0,0,0,0}, 4);
  endtask

  task automatic test_saturate();
    bit ok;
    int n;
    int x[8] = '{-256,-256,-256,-256,-256,-256,-256,-256};
    send(x, 1'b1, 1'b0, ok);
    wait_valid(n);
    tests++;
    if (!ok || n !== 8) begin fails++; $display("FAIL sat_handshake: ok=%b latency=%0d, required 1 8", ok, n); end
    tests++;
    if ($signed(Y[0 +: OUT_W]) !== -16'sd32768) begin
      fails++; $display("FAIL sat_Y0: got %0d required -32768", $signed(Y[0 +: OUT_W]));
    end
    tests++;
    if ($signed(Y[OUT_W +: OUT_W]) !== -16'sd28160) begin
      fails++; $display("FAIL sat_Y1: got %0d required -28160", $signed(Y[OUT_W +: OUT_W]));
    end
    tests++;
    if (Y !== model(x, 1'b1, 1'b0, 0)) begin
      fails++; $display("FAIL sat_Y: got %h required %h", Y, model(x, 1'b1, 1'b0, 0));
    end
    release_out();
  endtask

  task automatic test_shift2();
    bit ok;
    int n;
    int x[8] = '{1,0,0,0,0,0,0,0};
    logic [8*OUT_W-1:0] e;
    e = pack_y('{3,8,13,15,16,14,11,6});
    send(x, 1'b1, 1'b0, ok);
    wait_valid(n);
    tests++;
    if (out_valid2 !== 1'b1 || Y2 !== e) begin
      fails++; $display("FAIL shift2_Y: valid=%b got %h required %h", out_valid2, Y2, e);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    int a[8] = '{7,-3,100,-200,55,0,-1,255};
    int b[8] = '{-256,1,2,3,-4,5,-6,7};
    logic [8*OUT_W-1:0] ea, eb;
    ea = model(a, 1'b1, 1'b0, 0);
    eb = model(b, 1'b1, 1'b1, 0);
    send(a, 1'b1, 1'b0, ok);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (Y !== ea || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL hold_%0d: Y=%h valid=%b in_ready=%b, required %h 1 0", i, Y, out_valid, in_ready, ea);
      end
    end
    out_ready = 1'b1;
    send(b, 1'b1, 1'b1, ok);
    out_ready = 1'b0;
    tests++;
    if (!ok || out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_capture: ok=%b out_valid=%b, required 1 0", ok, out_valid);
    end
    wait_valid(n);
    tests++;
    if (n !== 8 || Y !== eb) begin
      fails++; $display("FAIL b2b_result: latency=%0d Y=%h, required 8 %h", n, Y, eb);
    end
    release_out();
  endtask

  task automatic test_random();
    bit ok, s8, inv;
    int n, x[8];
    logic [8*OUT_W-1:0] e, e2;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(511)) - 256;
      s8 = 1'($urandom); inv = 1'($urandom);
      e  = model(x, s8, inv, 0);
      e2 = model(x, s8, inv, 2);
      send(x, s8, inv, ok);
      wait_valid(n);
      tests++;
      if (!ok || n !== (s8 ? 8 : 4) || out_valid2 !== 1'b1) begin
        fails++; $display("FAIL rnd%0d_timing: ok=%b latency=%0d valid2=%b size8=%b", t, ok, n, out_valid2, s8);
      end
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      tests++;
      if (Y !== e || Y2 !== e2) begin
        fails++; $display("FAIL rnd%0d_Y: got %h / %h required %h / %h", t, Y, Y2, e, e2);
      end
      release_out();
      tests++;
      if (in_ready2 !== in_ready || out_valid2 !== out_valid) begin
        fails++; $display("FAIL rnd%0d_sync: in_ready2=%b out_valid2=%b, required %b %b", t, in_ready2, out_valid2, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_reset_midcalc();
    bit ok;
    int n;
    int x[8] = '{1,2,3,4,5,6,7,8};
    send(x, 1'b1, 1'b0, ok);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || Y !== '0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midcalc_reset: out_valid=%b Y=%h in_ready=%b, required 0 0 1", out_valid, Y, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || Y !== '0) begin
      fails++; $display("FAIL post_reset_idle: out_valid=%b Y=%h, required 0 0", out_valid, Y);
    end
    send(x, 1'b1, 1'b0, ok);
    wait_valid(n);
    tests++;
    if (n !== 8 || Y !== model(x, 1'b1, 1'b0, 0)) begin
      fails++; $display("FAIL post_reset_run: latency=%0d Y=%h required 8 %h", n, Y, model(x, 1'b1, 1'b0, 0));
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_fwd8_impulse();
    test_inv8_impulse();
    test_fwd4();
    test_saturate();
    test_shift2();
    test_back_to_back();
    test_random();
    test_reset_midcalc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
